// File: rtl/pca9685_pkg.sv
// Shared register map, mode-bit positions, reset values and LED register helpers
// for the PCA9685-compatible register bank.
package pca9685_pkg;

  localparam logic [7:0] ADDR_MODE1        = 8'h00;
  localparam logic [7:0] ADDR_MODE2        = 8'h01;
  localparam logic [7:0] ADDR_LED0_ON_L    = 8'h06;
  localparam logic [7:0] ADDR_LED_LAST     = 8'h45;
  localparam logic [7:0] ADDR_ALL_LED_ON_L = 8'hFA;
  localparam logic [7:0] ADDR_PRE_SCALE    = 8'hFE;

  localparam int unsigned MODE1_SLEEP  = 4;
  localparam int unsigned MODE1_AI     = 5;
  localparam int unsigned MODE2_OCH    = 3;
  localparam int unsigned MODE2_INVRT  = 4;
  localparam int unsigned MODE2_OUTDRV = 2;

  localparam logic [7:0] MODE1_RST    = 8'h11;
  localparam logic [7:0] MODE2_RST    = 8'h04;
  localparam logic [7:0] PRESCALE_MIN = 8'h03;

  typedef enum logic [1:0] {
    BYTE_ON_L  = 2'd0,
    BYTE_ON_H  = 2'd1,
    BYTE_OFF_L = 2'd2,
    BYTE_OFF_H = 2'd3
  } led_byte_e;

  // ON_H/OFF_H keep only bits [4:0]: bit4 is the full-on/full-off flag.
  typedef struct packed {
    logic [7:0] on_l;
    logic [4:0] on_h;
    logic [7:0] off_l;
    logic [4:0] off_h;
  } led_regs_t;

  localparam led_regs_t LED_RST = '{on_l: 8'h00, on_h: 5'h00, off_l: 8'h00, off_h: 5'h10};

  function automatic led_regs_t led_write(input led_regs_t r, input led_byte_e b,
                                          input logic [7:0] d);
    led_regs_t n;
    n = r;
    case (b)
      BYTE_ON_L:  n.on_l  = d;
      BYTE_ON_H:  n.on_h  = d[4:0];
      BYTE_OFF_L: n.off_l = d;
      default:    n.off_h = d[4:0];
    endcase
    return n;
  endfunction

  function automatic logic [7:0] led_read(input led_regs_t r, input led_byte_e b);
    case (b)
      BYTE_ON_L:  return r.on_l;
      BYTE_ON_H:  return {3'b000, r.on_h};
      BYTE_OFF_L: return r.off_l;
      default:    return {3'b000, r.off_h};
    endcase
  endfunction

endpackage

// File: rtl/pca9685_ptr_next.sv
// Register-pointer auto-increment: wraps to 0x00 after the last LED register
// and from PRE_SCALE or 0xFF, otherwise steps by one.
module pca9685_ptr_next
  import pca9685_pkg::*;
(
  input  logic [7:0] ptr_i,
  output logic [7:0] ptr_next_o
);

  always_comb begin
    if (ptr_i == ADDR_LED_LAST || ptr_i >= ADDR_PRE_SCALE) begin
      ptr_next_o = '0;
    end else begin
      ptr_next_o = ptr_i + 8'd1;
    end
  end

endmodule

// File: rtl/pca9685_regfile.sv
// PCA9685-compatible register bank fed by the I2C target byte stream; holds
// shadow/active LED copies and drives the PWM generator's channel read port.
module pca9685_regfile
  import pca9685_pkg::*;
#(
  parameter int unsigned NUM_CH       = 16,
  parameter logic [7:0]  PRESCALE_RST = 8'h1E
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        xfer_start_i,
  input  logic        stop_i,
  input  logic        wr_valid_i,
  input  logic [7:0]  wr_data_i,
  input  logic        rd_req_i,
  output logic [7:0]  rd_data_o,
  output logic        rd_valid_o,
  input  logic [3:0]  chan_sel_i,
  output logic [12:0] chan_on_o,
  output logic [12:0] chan_off_o,
  output logic [7:0]  prescale_o,
  output logic        sleep_o,
  output logic        invrt_o,
  output logic        outdrv_o
);

  logic [7:0]  mode1_q, mode1_d, mode2_q, mode2_d, prescale_q, prescale_d;
  logic [7:0]  ptr_q, ptr_d, rd_data_q, rd_data_d;
  logic        ptr_pending_q, ptr_pending_d, rd_valid_q, rd_valid_d;
  logic [12:0] chan_on_q, chan_on_d, chan_off_q, chan_off_d;
  led_regs_t   shadow_q [NUM_CH];
  led_regs_t   shadow_d [NUM_CH];
  led_regs_t   active_q [NUM_CH];
  led_regs_t   active_d [NUM_CH];

  logic [7:0]  ptr_inc, led_off, all_off, rd_byte;
  logic        in_led, in_all, pend_eff;
  logic [3:0]  led_idx;
  led_byte_e   led_byte, all_byte;

  pca9685_ptr_next u_ptr_next (
    .ptr_i      (ptr_q),
    .ptr_next_o (ptr_inc)
  );

  always_comb begin
    led_off  = ptr_q - ADDR_LED0_ON_L;
    all_off  = ptr_q - ADDR_ALL_LED_ON_L;
    in_led   = (led_off < 8'h40);
    in_all   = (all_off < 8'h04);
    led_idx  = led_off[5:2];
    led_byte = led_byte_e'(led_off[1:0]);
    all_byte = led_byte_e'(all_off[1:0]);
  end

  always_comb begin
    rd_byte = '0;
    if (ptr_q == ADDR_MODE1)          rd_byte = mode1_q;
    else if (ptr_q == ADDR_MODE2)     rd_byte = mode2_q;
    else if (ptr_q == ADDR_PRE_SCALE) rd_byte = prescale_q;
    else if (in_led)                  rd_byte = led_read(shadow_q[led_idx], led_byte);
  end

  always_comb begin
    mode1_d       = mode1_q;
    mode2_d       = mode2_q;
    prescale_d    = prescale_q;
    ptr_d         = ptr_q;
    rd_data_d     = rd_data_q;
    rd_valid_d    = 1'b0;
    shadow_d      = shadow_q;
    active_d      = active_q;
    // A START in the same cycle as a byte makes that byte the pointer.
    pend_eff      = ptr_pending_q | xfer_start_i;
    ptr_pending_d = pend_eff;

    if (wr_valid_i) begin
      if (pend_eff) begin
        ptr_d         = wr_data_i;
        ptr_pending_d = 1'b0;
      end else begin
        if (ptr_q == ADDR_MODE1) begin
          mode1_d = wr_data_i;
        end else if (ptr_q == ADDR_MODE2) begin
          mode2_d = wr_data_i;
        end else if (ptr_q == ADDR_PRE_SCALE) begin
          if (mode1_q[MODE1_SLEEP])
            prescale_d = (wr_data_i < PRESCALE_MIN) ? PRESCALE_MIN : wr_data_i;
        end else if (in_led) begin
          shadow_d[led_idx] = led_write(shadow_q[led_idx], led_byte, wr_data_i);
          if (mode2_q[MODE2_OCH])
            active_d[led_idx] = led_write(active_q[led_idx], led_byte, wr_data_i);
        end else if (in_all) begin
          for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            shadow_d[ch] = led_write(shadow_q[ch], all_byte, wr_data_i);
            if (mode2_q[MODE2_OCH])
              active_d[ch] = led_write(active_q[ch], all_byte, wr_data_i);
          end
        end
        if (mode1_q[MODE1_AI]) ptr_d = ptr_inc;
      end
    end else if (rd_req_i) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rd_byte;
      if (mode1_q[MODE1_AI]) ptr_d = ptr_inc;
    end

    // Commit uses shadow_d so a byte landing with STOP is included.
    if (stop_i && !mode2_q[MODE2_OCH]) active_d = shadow_d;

    chan_on_d  = {active_q[chan_sel_i].on_h,  active_q[chan_sel_i].on_l};
    chan_off_d = {active_q[chan_sel_i].off_h, active_q[chan_sel_i].off_l};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode1_q       <= MODE1_RST;
      mode2_q       <= MODE2_RST;
      prescale_q    <= PRESCALE_RST;
      ptr_q         <= '0;
      ptr_pending_q <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      chan_on_q     <= '0;
      chan_off_q    <= 13'h1000;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        shadow_q[ch] <= LED_RST;
        active_q[ch] <= LED_RST;
      end
    end else begin
      mode1_q       <= mode1_d;
      mode2_q       <= mode2_d;
      prescale_q    <= prescale_d;
      ptr_q         <= ptr_d;
      ptr_pending_q <= ptr_pending_d;
      rd_data_q     <= rd_data_d;
      rd_valid_q    <= rd_valid_d;
      chan_on_q     <= chan_on_d;
      chan_off_q    <= chan_off_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign chan_on_o  = chan_on_q;
  assign chan_off_o = chan_off_q;
  assign prescale_o = prescale_q;
  assign sleep_o    = mode1_q[MODE1_SLEEP];
  assign invrt_o    = mode2_q[MODE2_INVRT];
  assign outdrv_o   = mode2_q[MODE2_OUTDRV];

endmodule

// File: tb/tb_pca9685_regfile.sv
// Directed bench for pca9685_regfile: hand-computed register and PWM-port values.
module tb_pca9685_regfile;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        xfer_start_i, stop_i, wr_valid_i, rd_req_i;
  logic [7:0]  wr_data_i;
  logic [7:0]  rd_data_o;
  logic        rd_valid_o;
  logic [3:0]  chan_sel_i;
  logic [12:0] chan_on_o, chan_off_o;
  logic [7:0]  prescale_o;
  logic        sleep_o, invrt_o, outdrv_o;

  int n_tests = 0;
  int n_fail  = 0;

  pca9685_regfile #(.NUM_CH(16), .PRESCALE_RST(8'h1E)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .xfer_start_i (xfer_start_i),
    .stop_i       (stop_i),
    .wr_valid_i   (wr_valid_i),
    .wr_data_i    (wr_data_i),
    .rd_req_i     (rd_req_i),
    .rd_data_o    (rd_data_o),
    .rd_valid_o   (rd_valid_o),
    .chan_sel_i   (chan_sel_i),
    .chan_on_o    (chan_on_o),
    .chan_off_o   (chan_off_o),
    .prescale_o   (prescale_o),
    .sleep_o      (sleep_o),
    .invrt_o      (invrt_o),
    .outdrv_o     (outdrv_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All drive tasks enter and leave on a falling edge.
  task automatic send_start();
    xfer_start_i = 1'b1;
    @(negedge clk_i);
    xfer_start_i = 1'b0;
  endtask

  task automatic send_stop();
    stop_i = 1'b1;
    @(negedge clk_i);
    stop_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    wr_valid_i = 1'b1;
    wr_data_i  = b;
    @(negedge clk_i);
    wr_valid_i = 1'b0;
  endtask

  task automatic wr_seq(input logic [7:0] ptr, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3, input int n, input bit stop);
    send_start();
    send_byte(ptr);
    if (n > 0) send_byte(d0);
    if (n > 1) send_byte(d1);
    if (n > 2) send_byte(d2);
    if (n > 3) send_byte(d3);
    if (stop) send_stop();
  endtask

  task automatic check_chan(input string tag, input logic [3:0] ch,
                            input logic [12:0] exp_on, input logic [12:0] exp_off);
    chan_sel_i = ch;
    @(negedge clk_i);
    check_eq({tag, "_on"},  chan_on_o,  exp_on);
    check_eq({tag, "_off"}, chan_off_o, exp_off);
  endtask

  task automatic do_read(input string tag, input logic [7:0] exp);
    rd_req_i = 1'b1;
    @(negedge clk_i);
    rd_req_i = 1'b0;
    check_eq({tag, "_valid"}, rd_valid_o, 1);
    check_eq({tag, "_data"},  rd_data_o,  exp);
    @(negedge clk_i);
    check_eq({tag, "_valid_drop"}, rd_valid_o, 0);
    check_eq({tag, "_hold"},       rd_data_o,  exp);
  endtask

  initial begin
    rst_ni = 1'b0; xfer_start_i = 1'b0; stop_i = 1'b0; wr_valid_i = 1'b0;
    rd_req_i = 1'b0; wr_data_i = '0; chan_sel_i = '0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_rd_data",  rd_data_o,  0);
    check_eq("rst_rd_valid", rd_valid_o, 0);
    check_eq("rst_chan_on",  chan_on_o,  0);
    check_eq("rst_chan_off", chan_off_o, 13'h1000);
    check_eq("rst_prescale", prescale_o, 8'h1E);
    check_eq("rst_sleep",    sleep_o,    1);
    check_eq("rst_invrt",    invrt_o,    0);
    check_eq("rst_outdrv",   outdrv_o,   1);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int ch = 0; ch < 16; ch++) check_chan($sformatf("rst_ch%0d", ch), 4'(ch), 13'h0000, 13'h1000);

    // MODE1 = 0x31 (AI, SLEEP, ALLCALL), then LED0 programmed and committed on STOP.
    wr_seq(8'h00, 8'h31, 8'h00, 8'h00, 8'h00, 1, 1'b1);
    check_eq("mode1_sleep", sleep_o, 1);
    wr_seq(8'h06, 8'h10, 8'h00, 8'h20, 8'h01, 4, 1'b1);
    check_chan("led0", 4'd0, 13'h0010, 13'h0120);

    // OCH=0: LED1 stays stale until STOP.
    wr_seq(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1, 1'b1);
    check_eq("mode2_outdrv_clr", outdrv_o, 0);
    wr_seq(8'h0A, 8'h11, 8'h02, 8'h33, 8'h04, 4, 1'b0);
    check_chan("led1_stale", 4'd1, 13'h0000, 13'h1000);
    send_stop();
    check_eq("led1_stop_same_cycle", chan_off_o, 13'h1000);
    @(negedge clk_i);
    check_eq("led1_commit_on",  chan_on_o,  13'h0211);
    check_eq("led1_commit_off", chan_off_o, 13'h0433);

    // OCH=1: update without STOP; OFF_H 0xE5 keeps only bits [4:0].
    wr_seq(8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 1, 1'b1);
    wr_seq(8'h0A, 8'h22, 8'h01, 8'h44, 8'hE5, 4, 1'b0);
    check_chan("led1_och", 4'd1, 13'h0122, 13'h0544);
    send_stop();
    wr_seq(8'h0D, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b1);
    do_read("offh_mask", 8'h05);

    // PRE_SCALE only writable while sleeping; clamped to 3.
    wr_seq(8'h00, 8'h21, 8'h00, 8'h00, 8'h00, 1, 1'b1);
    check_eq("sleep_clr", sleep_o, 0);
    wr_seq(8'hFE, 8'h79, 8'h00, 8'h00, 8'h00, 1, 1'b1);
    check_eq("prescale_awake", prescale_o, 8'h1E);
    wr_seq(8'h00, 8'h31, 8'h00, 8'h00, 8'h00, 1, 1'b1);
    wr_seq(8'hFE, 8'h79, 8'h00, 8'h00, 8'h00, 1, 1'b1);
    check_eq("prescale_sleep", prescale_o, 8'h79);
    wr_seq(8'hFE, 8'h01, 8'h00, 8'h00, 8'h00, 1, 1'b1);
    check_eq("prescale_clamp", prescale_o, 8'h03);

    // ALL_LED OFF_L/OFF_H.
    wr_seq(8'hFC, 8'h00, 8'h08, 8'h00, 8'h00, 2, 1'b1);
    for (int ch = 0; ch < 16; ch++) begin
      chan_sel_i = 4'(ch);
      @(negedge clk_i);
      check_eq($sformatf("all_led_ch%0d", ch), chan_off_o, 13'h0800);
    end

    // Auto-increment wrap across 0x45 -> 0x00, then a reserved address.
    wr_seq(8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b1);
    send_start();
    do_read("rd_44", 8'h00);
    do_read("rd_45", 8'h08);
    do_read("rd_00", 8'h31);
    do_read("rd_01", 8'h08);
    do_read("rd_02_rsvd", 8'h00);
    send_stop();

    // Write and read request together: write wins, no read strobe.
    send_start();
    send_byte(8'h06);
    wr_valid_i = 1'b1; wr_data_i = 8'h55; rd_req_i = 1'b1;
    @(negedge clk_i);
    wr_valid_i = 1'b0; rd_req_i = 1'b0;
    check_eq("wr_rd_collide_valid", rd_valid_o, 0);
    send_stop();
    check_chan("wr_rd_collide_led0", 4'd0, 13'h0055, 13'h0800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
